// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_mmio
//  Description : Memory-mapped 8N1 UART transmitter. CPU stores push bytes
//                into a circular TX FIFO; a serializer drains it onto
//                uart_tx. Loads return status and the baud divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   baud;
    logic [15:0]   divisor;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx_reg;

    logic          fifo_empty;
    logic          fifo_full;
    logic          wr_en;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          bit_done;
    logic          baud_wr;
    logic          status_wr;
    logic [7:0]    head;

    // Bits of the bus that carry no meaning for this peripheral.
    logic          unused_bits;
    assign unused_bits = ^{wdata[31:16], addr[1:0]};

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_en      = sel & mem_write;
    assign push_req   = wr_en & (addr[3:2] == 2'd0);
    assign status_wr  = wr_en & (addr[3:2] == 2'd1);
    // Byte stores to BAUD are ignored; only halfword and word stores land.
    assign baud_wr    = wr_en & (addr[3:2] == 2'd2) &
                        ((funct3 == 3'b001) | (funct3 == 3'b010));
    assign bit_done   = (bit_cnt == divisor - 16'd1);
    // The serializer takes a byte from IDLE, or at the end of STOP so frames
    // run back-to-back without an idle gap.
    assign pop        = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));
    // A simultaneous pop frees a slot, so a push to a full FIFO is accepted.
    assign push       = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & fifo_full & ~pop;
    assign head       = fifo_mem[rd_ptr];
    assign uart_tx    = tx_reg;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag (write-1-to-clear) and the baud divisor register.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            baud     <= 16'(CLKS_PER_BIT);
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (status_wr & wdata[3]) begin
                overflow <= 1'b0;
            end
            if (baud_wr) begin
                baud <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
        end
    end

    // 8N1 serializer; the divisor is latched per frame so BAUD writes only
    // affect frames popped afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_reg  <= 1'b1;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            divisor <= 16'd1;
        end else begin
            case (state)
                IDLE: begin
                    tx_reg  <= 1'b1;
                    bit_cnt <= 16'd0;
                    if (pop) begin
                        shreg   <= head;
                        divisor <= baud;
                        tx_reg  <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        tx_reg  <= shreg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            tx_reg <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_reg  <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= 16'd0;
                        if (pop) begin
                            shreg   <= head;
                            divisor <= baud;
                            tx_reg  <= 1'b0;
                            state   <= START;
                        end else begin
                            tx_reg <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    tx_reg <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Load data decode; zero whenever the peripheral is not selected.
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr[3:2])
                2'd1: begin
                    rdata[0]        = (state != IDLE);
                    rdata[1]        = fifo_full;
                    rdata[2]        = fifo_empty;
                    rdata[3]        = overflow;
                    rdata[7+AW:8]   = count[AW-1:0];
                end
                2'd2: begin
                    rdata[15:0] = baud;
                end
                default: begin
                    rdata = 32'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
